// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types, opcodes, header field positions and argument counts for the GPU command front end.
package gpu_pkg;
  typedef enum logic [4:0] {
    BIT_1  = 5'd1,
    BIT_2  = 5'd2,
    BIT_4  = 5'd4,
    BIT_8  = 5'd8,
    BIT_16 = 5'd16
  } CTType;
  typedef enum logic [3:0] {
    OP_NOP       = 4'h0,
    OP_SET_IMAGE = 4'h1,
    OP_SET_CT    = 4'h2,
    OP_DRAW_RECT = 4'h3,
    OP_FENCE     = 4'h4
  } opcode_t;
  typedef enum logic [1:0] {FETCH_HEADER, FETCH_ARGS, ISSUE, WAIT_IDLE} state_t;
  localparam int OP_LSB = 28;
  localparam int CT_TYPE_LSB = 16;
  localparam int CT_USE_BIT = 21;
  localparam int ARGS_SET_IMAGE = 1;
  localparam int ARGS_DRAW_RECT = 3;
  function automatic logic [1:0] arg_last(input logic [3:0] op);
    return op == OP_DRAW_RECT ? 2'(ARGS_DRAW_RECT - 1) : 2'(ARGS_SET_IMAGE - 1);
  endfunction
  function automatic logic ct_type_ok(input logic [4:0] t);
    return t == BIT_1 || t == BIT_2 || t == BIT_4 || t == BIT_8 || t == BIT_16;
  endfunction
endpackage

// File: rtl/gpu_0_command.sv
// gpu_0_command: decodes the CPU command stream, holds drawing configuration and issues rectangle jobs.
module gpu_0_command
  import gpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [31:0]        cmd_data,
  input  logic               pipe_idle,
  output logic               se_valid,
  input  logic               se_ready,
  output logic [15:0]        se_start_x,
  output logic [15:0]        se_start_y,
  output logic [15:0]        se_width,
  output logic [15:0]        se_height,
  output logic signed [15:0] se_scale_x,
  output logic signed [15:0] se_scale_y,
  output logic               se_mirror_x,
  output logic               se_mirror_y,
  output logic [31:0]        cfg_base_address,
  output logic [15:0]        cfg_image_width,
  output logic [15:0]        cfg_ct_base_address,
  output CTType              cfg_ct_type,
  output logic               cfg_use_ct,
  output logic               busy,
  output logic               error
);
  state_t state, state_nx;
  logic [3:0] op, hdr_op;
  logic [1:0] cnt;
  logic dwell, pend_ct, pend_use_ct;
  logic [31:0] pend_base;
  logic [15:0] pend_width, pend_ct_base;
  CTType pend_ct_type;
  logic hdr_hs, arg_hs, last, degen, ct_ok, commit;
  assign hdr_op = cmd_data[31:OP_LSB];
  assign cmd_ready = rst && (state == FETCH_HEADER || state == FETCH_ARGS);
  assign hdr_hs = cmd_valid && cmd_ready && state == FETCH_HEADER;
  assign arg_hs = cmd_valid && cmd_ready && state == FETCH_ARGS;
  assign last = cnt == arg_last(op);
  // last DRAW_RECT word carries the scales; width/height are already registered
  assign degen = se_width == '0 || se_height == '0 || cmd_data[15:0] == '0 || cmd_data[31:16] == '0;
  assign ct_ok = ct_type_ok(cmd_data[CT_TYPE_LSB +: 5]);
  assign commit = state == WAIT_IDLE && dwell && pipe_idle;
  assign se_valid = state == ISSUE;
  assign busy = state != FETCH_HEADER || !pipe_idle;
  always_comb begin
    state_nx = state;
    if (hdr_hs)
      state_nx = (hdr_op == OP_SET_IMAGE || hdr_op == OP_DRAW_RECT) ? FETCH_ARGS :
                 (hdr_op == OP_SET_CT || hdr_op == OP_FENCE) ? WAIT_IDLE : FETCH_HEADER;
    if (arg_hs && last)
      state_nx = op == OP_SET_IMAGE ? WAIT_IDLE : degen ? FETCH_HEADER : ISSUE;
    if (state == ISSUE && se_ready) state_nx = FETCH_HEADER;
    if (commit) state_nx = FETCH_HEADER;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH_HEADER;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op <= '0;
      cnt <= '0;
      dwell <= 1'b0;
      pend_ct <= 1'b0;
      pend_use_ct <= 1'b0;
      pend_base <= '0;
      pend_width <= '0;
      pend_ct_base <= '0;
      pend_ct_type <= BIT_16;
      {se_start_y, se_start_x, se_height, se_width, se_scale_y, se_scale_x} <= '0;
      {se_mirror_y, se_mirror_x} <= '0;
      cfg_base_address <= '0;
      cfg_image_width <= '0;
      cfg_ct_base_address <= '0;
      cfg_ct_type <= BIT_16;
      cfg_use_ct <= 1'b0;
      error <= 1'b0;
    end else begin
      // dwell is low in the first WAIT_IDLE cycle, masking a lagging pipe_idle
      dwell <= state == WAIT_IDLE;
      if (hdr_hs) begin
        op <= hdr_op;
        cnt <= '0;
        if (hdr_op == OP_NOP && cmd_data[0]) error <= 1'b0;
        if (hdr_op == OP_SET_IMAGE) pend_width <= cmd_data[15:0];
        if (hdr_op == OP_SET_CT) begin
          pend_ct <= ct_ok;
          pend_ct_base <= cmd_data[15:0];
          pend_use_ct <= cmd_data[CT_USE_BIT];
          pend_ct_type <= cmd_data[CT_USE_BIT] ? CTType'(cmd_data[CT_TYPE_LSB +: 5]) : BIT_16;
          if (!ct_ok) error <= 1'b1;
        end
        if (hdr_op == OP_DRAW_RECT) {se_mirror_y, se_mirror_x} <= cmd_data[1:0];
        if (hdr_op > OP_FENCE) error <= 1'b1;
      end
      if (arg_hs) begin
        cnt <= cnt + 2'd1;
        if (op == OP_SET_IMAGE) pend_base <= cmd_data;
        else if (cnt == 2'd0) {se_start_y, se_start_x} <= cmd_data;
        else if (cnt == 2'd1) {se_height, se_width} <= cmd_data;
        else {se_scale_y, se_scale_x} <= cmd_data;
        if (op == OP_DRAW_RECT && last && degen) error <= 1'b1;
      end
      if (commit && op == OP_SET_IMAGE) begin
        cfg_base_address <= pend_base;
        cfg_image_width <= pend_width;
      end
      if (commit && op == OP_SET_CT && pend_ct) begin
        cfg_ct_base_address <= pend_ct_base;
        cfg_ct_type <= pend_ct_type;
        cfg_use_ct <= pend_use_ct;
      end
    end
  end
endmodule

// File: doc/gpu_0_command.md
# gpu_0_command

Front-end command stage of the GPU pipeline, directly upstream of the rectangle generator (stage 1). It consumes a 32-bit command word stream from the CPU-side command FIFO and decodes opcodes. It holds the persistent drawing configuration (image base address, image width, colour-table settings) for stages 2–4 and issues one rectangle job per DRAW_RECT to stage 1 over a valid/ready handshake. Configuration changes and FENCE wait until the whole pipeline has drained, so in-flight pixels never see new settings.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- cmd_valid  in  1  command word valid
- cmd_ready  out  1  command word accepted
- cmd_data  in  32  command word
- pipe_idle  in  1  stages 1–5 empty (top-level AND of stage idles)
- se_valid  out  1  rectangle job valid
- se_ready  in  1  stage 1 accepts job
- se_start_x, se_start_y  out  16 each  rectangle origin
- se_width, se_height  out  16 each  rectangle size
- se_scale_x, se_scale_y  out  16 each  signed scale (negative = downscale)
- se_mirror_x, se_mirror_y  out  1 each  mirror flags
- cfg_base_address  out  32  sprite-sheet base address
- cfg_image_width  out  16  sprite-sheet width in pixels
- cfg_ct_base_address  out  16  colour-table base
- cfg_ct_type  out  CTType  bits per pixel
- cfg_use_ct  out  1  colour table enabled
- busy  out  1  state != FETCH_HEADER or !pipe_idle
- error  out  1  sticky decode error

## Operation
- Header word: [31:28] opcode.
  - 0x0 NOP: 1 word. Bit 0 = 1 clears error.
  - 0x1 SET_IMAGE: 2 words. Header [15:0] = image_width; word 2 = base_address.
  - 0x2 SET_CT: 1 word. [15:0] ct_base, [20:16] ct_type, [21] use_ct.
  - 0x3 DRAW_RECT: 4 words. Header [0] mirror_x, [1] mirror_y; word 2 = {start_y, start_x}; word 3 = {height, width}; word 4 = {scale_y, scale_x}.
  - 0x4 FENCE: 1 word.
  - 0x5–0xF: illegal. Consumed as 1 word, sets error.
- States:
  - FETCH_HEADER: decode the header word. Single-word opcodes act immediately, except SET_CT and FENCE, which go to WAIT_IDLE. SET_IMAGE and DRAW_RECT go to FETCH_ARGS.
  - FETCH_ARGS: a 2-bit argument counter selects the target field.
    - After the last word: SET_IMAGE goes to WAIT_IDLE; DRAW_RECT goes to ISSUE.
  - ISSUE: se_valid = 1. On se_ready, return to FETCH_HEADER.
  - WAIT_IDLE: dwell at least 1 cycle, then wait for pipe_idle = 1.
    - Then commit any pending SET_IMAGE/SET_CT values to cfg_* and return to FETCH_HEADER.
- SET_CT:
  - ct_type outside {1,2,4,8,16}: error set, configuration unchanged. The command still waits for idle.
  - use_ct = 0: cfg_ct_type forced to BIT_16.
- DRAW_RECT with width = 0, height = 0, scale_x = 0 or scale_y = 0: error set, job discarded, return to FETCH_HEADER.
- No arithmetic. All fields are passed bit-exact.

## Timing
- cmd_ready = 1 exactly in FETCH_HEADER and FETCH_ARGS. It is decoded from the registered state and never depends on cmd_valid. Throughput is 1 word per cycle.
- DRAW_RECT: if the last argument handshake is at cycle N, se_valid = 1 at N+1. se_* stay stable while se_valid && !se_ready. cmd_ready = 0 during ISSUE.
- Back-to-back DRAW_RECT: after the se handshake at cycle M, the next header is accepted at M+1.
- WAIT_IDLE: if pipe_idle is sampled high at cycle K (K ≥ entry+1), cfg_* update at the K edge and cmd_ready = 1 at K+1. The one-cycle dwell covers pipe_idle lag after the last issue.
- FENCE/SET_* entered while se_valid is pending is impossible, because commands are serial.
- Reset (async assert, any state):
  - State goes to FETCH_HEADER.
  - cmd_ready = 0 while rst = 0.
  - se_valid = 0; all se_* = 0.
  - cfg_base_address = 0, cfg_image_width = 0, cfg_ct_base_address = 0, cfg_ct_type = BIT_16, cfg_use_ct = 0.
  - error = 0; busy reflects pipe_idle.
  - Partially fetched commands are lost. First cycle after release: cmd_ready = 1.
- Simultaneous error-clear NOP and an error event cannot occur, because commands are serial.

## Structure
- gpu_pkg: CTType, opcode enum (NOP, SET_IMAGE, SET_CT, DRAW_RECT, FENCE), state enum, header field bit positions, argument counts per opcode.
- No sub-module. The decoder and argument counter are small enough to stay inline.

## Test plan
- Reset: assert rst = 0 mid-FETCH_ARGS of DRAW_RECT → se_valid = 0, cfg_ct_type = BIT_16, cmd_ready = 1 one cycle after release; the partial command is dropped.
- DRAW_RECT stall: words 0x30000003, 0x00200010, 0x00080004, 0xFFFE0002 with se_ready held 0 for 5 cycles.
  - Required: se_start_x = 0x10, se_start_y = 0x20, se_width = 4, se_height = 8, se_scale_x = 2, se_scale_y = -2, both mirrors = 1.
  - Stable for 5 cycles; cmd_ready = 0 until the handshake.
- SET_IMAGE: 0x10000140, 0x80001000 with pipe_idle = 0 for 10 cycles.
  - cfg unchanged until pipe_idle rises; then cfg_image_width = 320, cfg_base_address = 0x80001000 at the next edge.
- SET_CT:
  - 0x20240100 → cfg_ct_base_address = 0x100, cfg_ct_type = 4, cfg_use_ct = 1.
  - 0x20030000 → error = 1, cfg unchanged.
  - 0x00000001 → error = 0.
- Illegal/degenerate: opcode 0x7 → error = 1, 1 word consumed. DRAW_RECT with width = 0 → no se_valid pulse, error = 1.
- FENCE after two back-to-back DRAW_RECTs: cmd_ready stays 0 until pipe_idle = 1 (held ≥ 1 cycle after entry); busy = 1 throughout.
